// File: rtl/store_queue_fwd.sv
// store_queue_fwd: in-order store queue between the LSU and the L1 D-cache
// write port, with youngest-match store-to-load forwarding.
//
// Optional feature macro: STQ_COALESCE_EN.
// When it is defined, a store whose address matches the youngest
// uncommitted entry merges into that entry instead of allocating a new one.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   st_valid/st_ready         store enqueue handshake; st_addr/st_data/st_mask
//   commit                    commit the oldest uncommitted entry
//   flush                     discard all uncommitted entries
//   ld_valid/ld_addr/ld_mask  load forwarding query
//   ld_resp_valid/ld_hit/ld_nack/ld_data  registered query response (1 cycle)
//   mem_valid/mem_ready       drain handshake; mem_addr/mem_data/mem_mask
//   count                     number of occupied entries
module store_queue_fwd #(
  parameter int unsigned DEPTH_EXP = 3,
  parameter int unsigned ADDR_W    = 30,
  parameter int unsigned DATA_W    = 32,
  localparam int unsigned MASK_W   = DATA_W / 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 st_valid,
  output logic                 st_ready,
  input  logic [ADDR_W-1:0]    st_addr,
  input  logic [DATA_W-1:0]    st_data,
  input  logic [MASK_W-1:0]    st_mask,
  input  logic                 commit,
  input  logic                 flush,
  input  logic                 ld_valid,
  input  logic [ADDR_W-1:0]    ld_addr,
  input  logic [MASK_W-1:0]    ld_mask,
  output logic                 ld_resp_valid,
  output logic                 ld_hit,
  output logic                 ld_nack,
  output logic [DATA_W-1:0]    ld_data,
  output logic                 mem_valid,
  input  logic                 mem_ready,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_data,
  output logic [MASK_W-1:0]    mem_mask,
  output logic [DEPTH_EXP:0]   count
);

  localparam int unsigned DEPTH = 1 << DEPTH_EXP;
  localparam int unsigned PW    = DEPTH_EXP + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [MASK_W-1:0] mask_q [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0] head, cmt, tail;
  logic [PW-1:0] cmt_nxt;
  logic [DEPTH_EXP-1:0] head_idx, tail_idx, tail_m1_idx;
  logic full, commit_ok, drain_fire, st_fire, alloc, merge_hit;

  assign head_idx    = head[DEPTH_EXP-1:0];
  assign tail_idx    = tail[DEPTH_EXP-1:0];
  assign tail_m1_idx = tail_idx - DEPTH_EXP'(1);

  assign count      = tail - head;
  assign full       = (count == PW'(DEPTH));
  assign commit_ok  = commit && (cmt != tail);
  assign cmt_nxt    = cmt + PW'(commit_ok);

`ifdef STQ_COALESCE_EN
  assign merge_hit = (cmt != tail) && (addr_q[tail_m1_idx] == st_addr);
`else
  assign merge_hit = 1'b0;
`endif

  // Full is taken from registered state, so a same-cycle drain does not
  // open a slot until the following cycle.
  assign st_ready   = !rst && (!full || merge_hit) && !flush;
  assign st_fire    = st_valid && st_ready;
  assign alloc      = st_fire && !merge_hit;

  assign mem_valid  = (head != cmt);
  assign drain_fire = mem_valid && mem_ready;
  assign mem_addr   = mem_valid ? addr_q[head_idx] : '0;
  assign mem_data   = mem_valid ? data_q[head_idx] : '0;
  assign mem_mask   = mem_valid ? mask_q[head_idx] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      cmt  <= '0;
      tail <= '0;
    end else begin
      head <= head + PW'(drain_fire);
      cmt  <= cmt_nxt;
      // Flush rewinds tail to the commit point after this cycle's commit.
      tail <= flush ? cmt_nxt : tail + PW'(alloc);
    end
  end

  always_ff @(posedge clk) begin
    if (alloc) begin
      addr_q[tail_idx] <= st_addr;
      data_q[tail_idx] <= st_data;
      mask_q[tail_idx] <= st_mask;
    end
`ifdef STQ_COALESCE_EN
    if (st_fire && merge_hit) begin
      for (int unsigned b = 0; b < MASK_W; b++) begin
        if (st_mask[b]) data_q[tail_m1_idx][8*b +: 8] <= st_data[8*b +: 8];
      end
      mask_q[tail_m1_idx] <= mask_q[tail_m1_idx] | st_mask;
    end
`endif
  end

  // Scan oldest to youngest over the live window; the last match wins,
  // which gives youngest priority independent of physical wrap.
  logic                 fwd_match;
  logic [DATA_W-1:0]    fwd_data;
  logic [MASK_W-1:0]    fwd_mask;
  logic [DEPTH_EXP-1:0] fwd_idx;
  logic                 fwd_full;

  always_comb begin
    fwd_match = 1'b0;
    fwd_data  = '0;
    fwd_mask  = '0;
    fwd_idx   = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      fwd_idx = head_idx + DEPTH_EXP'(k);
      if ((PW'(k) < count) && (addr_q[fwd_idx] == ld_addr)) begin
        fwd_match = 1'b1;
        fwd_data  = data_q[fwd_idx];
        fwd_mask  = mask_q[fwd_idx];
      end
    end
  end

  assign fwd_full = fwd_match && ((fwd_mask & ld_mask) == ld_mask);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_resp_valid <= 1'b0;
      ld_hit        <= 1'b0;
      ld_nack       <= 1'b0;
      ld_data       <= '0;
    end else begin
      ld_resp_valid <= ld_valid;
      ld_hit        <= ld_valid && fwd_full;
      ld_nack       <= ld_valid && fwd_match && !fwd_full;
      ld_data       <= (ld_valid && fwd_full) ? fwd_data : '0;
    end
  end

endmodule

// File: tb/tb_store_queue_fwd.sv
module tb_store_queue_fwd;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st_valid = 1'b0, commit = 1'b0, flush = 1'b0, ld_valid = 1'b0;
  logic        mem_ready = 1'b1;
  logic [29:0] st_addr = '0, ld_addr = '0;
  logic [31:0] st_data = '0;
  logic [3:0]  st_mask = '0, ld_mask = '0;
  logic        st_ready, ld_resp_valid, ld_hit, ld_nack, mem_valid;
  logic [31:0] ld_data, mem_data;
  logic [29:0] mem_addr;
  logic [3:0]  mem_mask, count;

  store_queue_fwd #(.DEPTH_EXP(3), .ADDR_W(30), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_data(st_data), .st_mask(st_mask),
    .commit(commit), .flush(flush),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_mask(ld_mask),
    .ld_resp_valid(ld_resp_valid), .ld_hit(ld_hit), .ld_nack(ld_nack),
    .ld_data(ld_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_mask(mem_mask),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [29:0] a; logic [31:0] d; logic [3:0] m; } ent_t;
  typedef struct { logic hit; logic nack; logic [31:0] data; } ldexp_t;

  ent_t   q_unc[$];   // enqueued, not yet committed
  ent_t   q_drn[$];   // committed, not yet drained
  ldexp_t q_ld[$];    // expected load responses

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic st(input logic [29:0] a, input logic [31:0] d, input logic [3:0] m);
    st_valid = 1'b1; st_addr = a; st_data = d; st_mask = m;
  endtask

  task automatic ld(input logic [29:0] a, input logic [3:0] m,
                    input logic h, input logic n, input logic [31:0] d);
    ldexp_t e;
    ld_valid = 1'b1; ld_addr = a; ld_mask = m;
    e.hit = h; e.nack = n; e.data = d;
    q_ld.push_back(e);
  endtask

  // One clock: check pre-edge state against the model, advance the model,
  // then check the registered load response after the edge.
  task automatic tick();
    bit     ld_now, mrg, exp_rdy;
    int     n_live;
    ent_t   e;
    ldexp_t x;
    @(negedge clk);
    n_live = q_unc.size() + q_drn.size();
    mrg = 1'b0;
`ifdef STQ_COALESCE_EN
    if (q_unc.size() != 0 && q_unc[q_unc.size()-1].a == st_addr) mrg = 1'b1;
`endif
    exp_rdy = ((n_live < 8) || mrg) && !flush;
    chk("count", count, n_live);
    chk("st_ready", st_ready, exp_rdy);
    chk("mem_valid", mem_valid, q_drn.size() != 0);
    if (q_drn.size() != 0) begin
      chk("mem_addr", mem_addr, q_drn[0].a);
      chk("mem_data", mem_data, q_drn[0].d);
      chk("mem_mask", mem_mask, q_drn[0].m);
      if (mem_ready) void'(q_drn.pop_front());
    end
    if (commit && q_unc.size() != 0) q_drn.push_back(q_unc.pop_front());
    if (flush) q_unc.delete();
    if (st_valid && exp_rdy) begin
      if (mrg) begin
        e = q_unc[q_unc.size()-1];
        for (int b = 0; b < 4; b++) if (st_mask[b]) e.d[8*b +: 8] = st_data[8*b +: 8];
        e.m = e.m | st_mask;
        q_unc[q_unc.size()-1] = e;
      end else begin
        e.a = st_addr; e.d = st_data; e.m = st_mask;
        q_unc.push_back(e);
      end
    end
    ld_now = ld_valid;
    @(posedge clk);
    #1;
    st_valid = 1'b0; commit = 1'b0; flush = 1'b0; ld_valid = 1'b0;
    if (ld_now) begin
      vectors++;
      assert (q_ld.size() != 0) else begin
        miscompares++;
        $error("FAIL ld_scoreboard: got empty expected pending entry");
      end
      if (q_ld.size() != 0) begin
        x = q_ld.pop_front();
        chk("ld_resp_valid", ld_resp_valid, 1);
        chk("ld_hit", ld_hit, x.hit);
        chk("ld_nack", ld_nack, x.nack);
        chk("ld_data", ld_data, x.data);
      end
    end else begin
      chk("ld_resp_idle", ld_resp_valid, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    #1;
    chk("rst_count", count, 0);
    chk("rst_st_ready", st_ready, 0);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_resp", ld_resp_valid, 0);
    chk("rst_hit", ld_hit, 0);
    chk("rst_data", ld_data, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single store, commit, drain
    st(30'h10, 32'hAABBCCDD, 4'hF); tick();
    commit = 1'b1; tick();
    repeat (2) tick();

    // Youngest match wins
    st(30'h10, 32'h1, 4'hF); tick();
    st(30'h10, 32'h2, 4'hF); tick();
    ld(30'h10, 4'h3, 1'b1, 1'b0, 32'h2); tick();
    commit = 1'b1; tick();
    commit = 1'b1; tick();

    // Partial overlap and miss
    st(30'h20, 32'h1234, 4'h3); tick();
    ld(30'h20, 4'hF, 1'b0, 1'b1, 32'h0); tick();
    ld(30'h24, 4'hF, 1'b0, 1'b0, 32'h0); tick();
    flush = 1'b1; tick();
    repeat (3) tick();

    // Fill to full, refused store, drain while full, wrap
    mem_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      st(30'h100 + 30'(i), 32'h50 + 32'(i), 4'hF); tick();
    end
    st(30'h200, 32'hDEAD, 4'hF);
    ld(30'h105, 4'hF, 1'b1, 1'b0, 32'h55); tick();
    for (int i = 0; i < 3; i++) begin
      commit = 1'b1; tick();
    end
    mem_ready = 1'b1;
    st(30'h200, 32'hDEAD, 4'hF); tick();
    repeat (2) tick();
    mem_ready = 1'b0;
    st(30'h300, 32'h60, 4'hF); tick();
    st(30'h301, 32'h61, 4'hF); tick();
    st(30'h105, 32'h99, 4'hF); tick();
    ld(30'h105, 4'hF, 1'b1, 1'b0, 32'h99); tick();
    ld(30'h107, 4'h1, 1'b1, 1'b0, 32'h57); tick();
    ld(30'h300, 4'hF, 1'b1, 1'b0, 32'h60); tick();
    commit = 1'b1; tick();
    commit = 1'b1; tick();
    flush = 1'b1; tick();
    ld(30'h300, 4'hF, 1'b0, 1'b0, 32'h0);
    mem_ready = 1'b1; tick();
    repeat (3) tick();

    // Flush keeps only committed entries
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      st(30'h400 + 30'(i), 32'h70 + 32'(i), 4'hF); tick();
    end
    commit = 1'b1; tick();
    commit = 1'b1; tick();
    flush = 1'b1; tick();
    ld(30'h402, 4'hF, 1'b0, 1'b0, 32'h0); tick();
    mem_ready = 1'b1;
    repeat (4) tick();

`ifdef STQ_COALESCE_EN
    // Coalescing into the youngest uncommitted entry
    st(30'h30, 32'h11, 4'h1); tick();
    st(30'h30, 32'h2200, 4'h2); tick();
    ld(30'h30, 4'h3, 1'b1, 1'b0, 32'h2211); tick();
    commit = 1'b1; tick();
    repeat (3) tick();
`endif

    // Reset while an entry waits to drain
    mem_ready = 1'b0;
    st(30'h500, 32'h5A5A, 4'hF); tick();
    commit = 1'b1; tick();
    tick();
    rst = 1'b1;
    #2;
    chk("rst_mid_count", count, 0);
    chk("rst_mid_mem_valid", mem_valid, 0);
    q_unc.delete();
    q_drn.delete();
    #1 rst = 1'b0;
    mem_ready = 1'b1;
    repeat (2) tick();

    chk("ld_queue_empty", q_ld.size(), 0);
    chk("drain_queue_empty", q_drn.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
